filo_arbiter: RTL and testbench
===============================

// Module: filo_arbiter
// PURPOSE
//  Shares one 32-bit LIFO stack (push/pop via read_write) between two requesters, A and B.
//  Round-robin arbitration, one stack operation at a time, own occupancy counter.
//  Pushes to a full stack and pops from an empty stack are refused with a NACK and are never issued.
//  Sits between client logic and the stack instance; the stack is driven only through this block.
// PARAMETERS
//  WIDTH  32  data width of requester and stack data buses
//  DEPTH  16  stack capacity in entries; must match the attached stack
//  CW     6   occupancy counter width; must satisfy 2**CW > DEPTH
// PORTS
//  clk             in   1      single clock; all state updates on rising edge
//  reset           in   1      asynchronous, active-high reset
//  a_req           in   1      requester A operation request, level, held until a_ack or a_nack
//  a_op            in   1      A operation: 0 = push, 1 = pop; stable while a_req=1
//  a_wdata         in   WIDTH  A push data; stable while a_req=1
//  a_ack           out  1      one-cycle pulse: A operation completed
//  a_nack          out  1      one-cycle pulse: A operation refused (full push / empty pop)
//  b_req,b_op,b_wdata,b_ack,b_nack     as A, for requester B
//  rdata           out  WIDTH  pop result; valid in the cycle of a pop ack, held until next pop ack
//  stk_en          out  1      one-cycle command strobe to stack
//  stk_read_write  out  1      stack mode: 0 = push, 1 = pop; valid when stk_en=1
//  stk_data_in     out  WIDTH  stack push data; valid when stk_en=1
//  stk_data_out    in   WIDTH  stack pop data; valid 1 cycle after a pop strobe
//  count           out  CW     current occupancy, 0..DEPTH
//  empty           out  1      count == 0
//  full            out  1      count == DEPTH
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, count=0, empty=1, full=0, last_grant=B (A wins first tie).
//   All ack/nack pulses=0, stk_en=0, stk_read_write=0, stk_data_in=0, rdata=0.
//   Reset mid-operation aborts the operation with no ack and no nack; count returns to 0.
//  FSM, all outputs registered:
//   IDLE   -- Pick a requester: only one req high -> that one; both high -> not last_grant.
//             Record the granted side in gnt and last_grant.
//             Refused (push with full=1, or pop with empty=1) -> REJECT; otherwise -> ISSUE.
//   ISSUE  -- Drive stk_en=1 for one cycle with stk_read_write=op and stk_data_in=wdata.
//             Update count: push -> +1, pop -> -1; empty/full follow in the same cycle.
//             -> WAIT.
//   WAIT   -- On a pop, capture stk_data_out into rdata. -> DONE.
//   DONE   -- gnt ack=1 for one cycle. -> IDLE.
//   REJECT -- gnt nack=1 for one cycle; stack and count untouched. -> IDLE.
//  Handshake:
//   Latency from grant to ack is 3 cycles (ISSUE, WAIT, DONE); from grant to nack is 1 cycle.
//   The requester deasserts req in the cycle after ack/nack, or re-requests at once.
//   IDLE re-arbitrates in the cycle after ack/nack, so the other side wins if both are pending.
//   A req dropped before ack is a protocol error: the operation still completes and acks.
//   op/wdata are sampled only in IDLE at grant; later changes are ignored.
//   Exactly one of the four ack/nack outputs is high in any cycle, or none.
//  Boundaries:
//   count saturates by construction: ISSUE is only reached when legal.
//   Never wraps past DEPTH or below 0.
//   Push reaching count==DEPTH sets full in that ISSUE cycle; the next push is nacked.
//   Pop reaching 0 sets empty; the next pop is nacked and rdata keeps its old value.
//   Simultaneous requests: the loser keeps req high and is served on the next arbitration, never starved.
// TESTING
//  Reset: assert reset mid-ISSUE -> stk_en, ack, nack, count drop to 0 at once; empty=1.
//  Single push/pop: A pushes 0x0000_00AA -> stk_en 1 cycle after grant, a_ack 3 cycles after grant,
//   count=1; A pops -> rdata=0x0000_00AA at a_ack, count=0.
//  Round robin: A and B both hold push requests for 4 operations each -> grants alternate A,B,A,B...
//   starting with A; count=8.
//  Full: 16 pushes of values 1..16 -> full=1 at count=16; 17th push -> nack with no stk_en;
//   pops return 16 down to 1.
//  Empty: pop after reset -> a_nack 1 cycle after grant, stk_en stays 0, rdata=0, count=0.
//  Mixed contention: B pops while A pushes at count=1 -> A granted on the tie, B acked next;
//   B's rdata is A's pushed value.

Source files
------------

// File: rtl/filo_arbiter.sv
// filo_arbiter: shares one LIFO stack between requesters A and B.
// Round-robin arbitration, one stack operation in flight, local occupancy tracking.
// Illegal operations (push when full, pop when empty) are answered with a nack
// and never reach the stack.
module filo_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_req,
    input  logic             a_op,
    input  logic [WIDTH-1:0] a_wdata,
    output logic             a_ack,
    output logic             a_nack,
    input  logic             b_req,
    input  logic             b_op,
    input  logic [WIDTH-1:0] b_wdata,
    output logic             b_ack,
    output logic             b_nack,
    output logic [WIDTH-1:0] rdata,
    output logic             stk_en,
    output logic             stk_read_write,
    output logic [WIDTH-1:0] stk_data_in,
    input  logic [WIDTH-1:0] stk_data_out,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
    localparam logic [CW-1:0] OneCnt   = CW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StDone,
        StReject
    } state_e;

    state_e           state_q;
    logic             gnt_q;        // side being served: 0 = A, 1 = B
    logic             last_grant_q; // side served last: 0 = A, 1 = B
    logic             op_q;         // operation latched at grant: 0 = push, 1 = pop

    logic             grant_b;
    logic             sel_op;
    logic [WIDTH-1:0] sel_data;
    logic             refuse;

    // Pick a requester (tie goes to the side not served last) and judge legality.
    always_comb begin
        grant_b  = b_req & (~a_req | ~last_grant_q);
        sel_op   = grant_b ? b_op : a_op;
        sel_data = grant_b ? b_wdata : a_wdata;
        refuse   = sel_op ? empty : full;
    end

    // Operation sequencer; every output is a register written here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            gnt_q          <= 1'b0;
            last_grant_q   <= 1'b1;
            op_q           <= 1'b0;
            a_ack          <= 1'b0;
            a_nack         <= 1'b0;
            b_ack          <= 1'b0;
            b_nack         <= 1'b0;
            rdata          <= '0;
            stk_en         <= 1'b0;
            stk_read_write <= 1'b0;
            stk_data_in    <= '0;
            count          <= '0;
            empty          <= 1'b1;
            full           <= 1'b0;
        end else begin
            // Pulses default low; each state raises at most one of them.
            a_ack  <= 1'b0;
            a_nack <= 1'b0;
            b_ack  <= 1'b0;
            b_nack <= 1'b0;
            stk_en <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (a_req || b_req) begin
                        gnt_q        <= grant_b;
                        last_grant_q <= grant_b;
                        op_q         <= sel_op;
                        if (refuse) begin
                            state_q <= StReject;
                            if (grant_b) begin
                                b_nack <= 1'b1;
                            end else begin
                                a_nack <= 1'b1;
                            end
                        end else begin
                            state_q        <= StIssue;
                            stk_en         <= 1'b1;
                            stk_read_write <= sel_op;
                            stk_data_in    <= sel_data;
                            // Occupancy moves with the strobe so flags are current in ISSUE.
                            if (sel_op) begin
                                count <= count - OneCnt;
                                empty <= (count == OneCnt);
                                full  <= 1'b0;
                            end else begin
                                count <= count + OneCnt;
                                empty <= 1'b0;
                                full  <= (count == DepthCnt - OneCnt);
                            end
                        end
                    end
                end
                StIssue: begin
                    state_q <= StWait;
                end
                StWait: begin
                    // Stack pop data arrives one cycle after the strobe.
                    if (op_q) begin
                        rdata <= stk_data_out;
                    end
                    if (gnt_q) begin
                        b_ack <= 1'b1;
                    end else begin
                        a_ack <= 1'b1;
                    end
                    state_q <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                StReject: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filo_arbiter.sv
// tb_filo_arbiter: directed and randomized checks of filo_arbiter against a
// transaction-level model (a queue for the stack, a flag for round-robin state).
module tb_filo_arbiter;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int CW    = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             a_req, a_op, b_req, b_op;
    logic [WIDTH-1:0] a_wdata, b_wdata;
    logic             a_ack, a_nack, b_ack, b_nack;
    logic [WIDTH-1:0] rdata;
    logic             stk_en, stk_read_write;
    logic [WIDTH-1:0] stk_data_in, stk_data_out;
    logic [CW-1:0]    count;
    logic             empty, full;

    always #5 clk = ~clk;

    filo_arbiter #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CW   (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .a_req         (a_req),
        .a_op          (a_op),
        .a_wdata       (a_wdata),
        .a_ack         (a_ack),
        .a_nack        (a_nack),
        .b_req         (b_req),
        .b_op          (b_op),
        .b_wdata       (b_wdata),
        .b_ack         (b_ack),
        .b_nack        (b_nack),
        .rdata         (rdata),
        .stk_en        (stk_en),
        .stk_read_write(stk_read_write),
        .stk_data_in   (stk_data_in),
        .stk_data_out  (stk_data_out),
        .count         (count),
        .empty         (empty),
        .full          (full)
    );

    // Attached stack device: registered pop data, one cycle after the strobe.
    logic [WIDTH-1:0] stk_mem [DEPTH];
    int               stk_sp;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            stk_sp       <= 0;
            stk_data_out <= '0;
        end else if (stk_en) begin
            if (!stk_read_write) begin
                if (stk_sp < DEPTH) stk_mem[stk_sp[3:0]] <= stk_data_in;
                stk_sp <= stk_sp + 1;
            end else if (stk_sp > 0) begin
                stk_data_out <= stk_mem[4'(stk_sp - 1)];
                stk_sp       <= stk_sp - 1;
            end
        end
    end

    // Reference model state.
    int               n_checks = 0;
    int               n_errors = 0;
    int unsigned      model_q[$];
    logic [WIDTH-1:0] rdata_m;
    bit               last_a;
    bit               a_pend, b_pend, a_op_m, b_op_m;
    logic [WIDTH-1:0] a_dat_m, b_dat_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_a(input bit op, input logic [WIDTH-1:0] d);
        a_pend  = 1'b1;
        a_op_m  = op;
        a_dat_m = d;
    endtask

    task automatic set_b(input bit op, input logic [WIDTH-1:0] d);
        b_pend  = 1'b1;
        b_op_m  = op;
        b_dat_m = d;
    endtask

    task automatic model_reset();
        model_q.delete();
        rdata_m = '0;
        last_a  = 1'b0;
        a_pend  = 1'b0;
        b_pend  = 1'b0;
    endtask

    // Drive pending requests from IDLE, follow one transaction to its response,
    // check it against the model, then drop the served side's request.
    task automatic run_round(output bit won_a);
        bit               exp_a, exp_ack, op, got;
        logic [WIDTH-1:0] wd;
        int               exp_cnt, exp_k, k;
        logic [3:0]       resp, exp_resp;
        exp_a   = (a_pend && b_pend) ? !last_a : a_pend;
        op      = exp_a ? a_op_m : b_op_m;
        wd      = exp_a ? a_dat_m : b_dat_m;
        exp_ack = op ? (model_q.size() != 0) : (model_q.size() < DEPTH);
        exp_cnt = model_q.size();
        if (exp_ack) exp_cnt = op ? exp_cnt - 1 : exp_cnt + 1;
        exp_k    = exp_ack ? 4 : 2;
        exp_resp = exp_a ? (exp_ack ? 4'b1000 : 4'b0100) : (exp_ack ? 4'b0010 : 4'b0001);
        a_req   = a_pend;
        a_op    = a_op_m;
        a_wdata = a_dat_m;
        b_req   = b_pend;
        b_op    = b_op_m;
        b_wdata = b_dat_m;
        k    = 0;
        got  = 1'b0;
        resp = '0;
        while (!got && k < 10) begin
            @(negedge clk);
            k++;
            resp = {a_ack, a_nack, b_ack, b_nack};
            check("resp_onehot", 32'($countones(resp) <= 1), 1);
            if (k == 2 && exp_ack) begin
                check("stk_en", 32'(stk_en), 1);
                check("stk_rw", 32'(stk_read_write), 32'(op));
                if (!op) check("stk_data_in", stk_data_in, wd);
                check("count_issue", 32'(count), 32'(exp_cnt));
            end else begin
                check("stk_en_quiet", 32'(stk_en), 0);
            end
            // Winner's op/data are only sampled at grant; disturb them mid-flight.
            if (k == 3 && exp_ack) begin
                if (exp_a) begin
                    a_op    = 1'($urandom);
                    a_wdata = $urandom;
                end else begin
                    b_op    = 1'($urandom);
                    b_wdata = $urandom;
                end
            end
            got = (resp != 4'b0);
        end
        check("resp_seen", 32'(got), 1);
        check("latency", 32'(k), 32'(exp_k));
        check("resp_which", 32'(resp), 32'(exp_resp));
        last_a = exp_a;
        if (exp_ack) begin
            if (op) rdata_m = model_q.pop_back();
            else model_q.push_back(wd);
        end
        check("count", 32'(count), 32'(model_q.size()));
        check("empty", 32'(empty), 32'(model_q.size() == 0));
        check("full", 32'(full), 32'(model_q.size() == DEPTH));
        check("rdata", rdata, rdata_m);
        won_a = exp_a;
        if (exp_a) a_pend = 1'b0;
        else b_pend = 1'b0;
        @(posedge clk);
        #1;
        a_req = a_pend;
        b_req = b_pend;
    endtask

    task automatic rand_fill(input int pop_pct);
        if (!a_pend && int'($urandom_range(99)) < 60)
            set_a(int'($urandom_range(99)) < pop_pct, $urandom);
        if (!b_pend && int'($urandom_range(99)) < 60)
            set_b(int'($urandom_range(99)) < pop_pct, $urandom);
        if (!a_pend && !b_pend) begin
            if ($urandom_range(1) == 0) set_a(int'($urandom_range(99)) < pop_pct, $urandom);
            else set_b(int'($urandom_range(99)) < pop_pct, $urandom);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit w;
        int na, nb;
        reset   = 1'b1;
        a_req   = 1'b0;
        a_op    = 1'b0;
        a_wdata = '0;
        b_req   = 1'b0;
        b_op    = 1'b0;
        b_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_stk_en", 32'(stk_en), 0);
        check("rst_stk_rw", 32'(stk_read_write), 0);
        check("rst_stk_din", stk_data_in, 0);
        check("rst_pulses", 32'({a_ack, a_nack, b_ack, b_nack}), 0);
        check("rst_rdata", rdata, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Round robin: both sides push 4 each, grants alternate starting with A.
        na = 0;
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            if (!a_pend && na < 4) begin set_a(1'b0, 32'h100 + 32'(na)); na++; end
            if (!b_pend && nb < 4) begin set_b(1'b0, 32'h200 + 32'(nb)); nb++; end
            run_round(w);
            check("rr_order", 32'(w), 32'(i % 2 == 0));
        end
        check("rr_count", 32'(count), 8);

        // Drain through B.
        for (int i = 0; i < 8; i++) begin
            set_b(1'b1, '0);
            run_round(w);
        end

        // Pop on empty is refused.
        set_a(1'b1, '0);
        run_round(w);

        // Single push and pop.
        set_a(1'b0, 32'h0000_00AA);
        run_round(w);
        check("single_count", 32'(count), 1);
        set_a(1'b1, '0);
        run_round(w);
        check("single_rdata", rdata, 32'h0000_00AA);

        // Fill to capacity, overflow push refused, then drain in LIFO order.
        for (int v = 1; v <= DEPTH; v++) begin
            set_a(1'b0, 32'(v));
            run_round(w);
        end
        check("fill_full", 32'(full), 1);
        set_a(1'b0, 32'd17);
        run_round(w);
        for (int i = 0; i < DEPTH; i++) begin
            set_a(1'b1, '0);
            run_round(w);
            check("fill_pop_order", rdata, 32'(DEPTH - i));
        end

        // Mixed contention at count=1: A push wins the tie, B pops A's value.
        set_b(1'b0, 32'h55);
        run_round(w);
        set_a(1'b0, 32'h1234_5678);
        set_b(1'b1, '0);
        run_round(w);
        check("mixed_first_a", 32'(w), 1);
        run_round(w);
        check("mixed_rdata", rdata, 32'h1234_5678);

        // Randomized traffic with push-heavy, pop-heavy and balanced phases.
        for (int i = 0; i < 60; i++) begin rand_fill(25); run_round(w); end
        for (int i = 0; i < 60; i++) begin rand_fill(75); run_round(w); end
        for (int i = 0; i < 60; i++) begin rand_fill(50); run_round(w); end

        // Reset in the middle of an issued operation.
        a_pend  = 1'b0;
        b_pend  = 1'b0;
        a_req   = 1'b1;
        a_op    = (model_q.size() == DEPTH);
        a_wdata = 32'hDEAD_BEEF;
        b_req   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_pre_en", 32'(stk_en), 1);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_stk_en", 32'(stk_en), 0);
        check("rst_mid_pulses", 32'({a_ack, a_nack, b_ack, b_nack}), 0);
        check("rst_mid_count", 32'(count), 0);
        check("rst_mid_empty", 32'(empty), 1);
        a_req = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Pop straight after reset is refused and rdata stays 0.
        set_a(1'b1, '0);
        run_round(w);
        check("post_rst_rdata", rdata, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
